// File: rtl/i2c_slave_axis.sv
// I2C target with a 7-bit address, AXI-stream write-byte output and AXI-stream read-byte input.
// SCL/SDA are oversampled on clk_i; no clock stretching.
module i2c_slave_axis #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       arst_i,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe_o,
   output logic [7:0] m_axis_tdata_o,
   output logic       m_axis_tvalid_o,
   input  logic       m_axis_tready_i,
   input  logic [7:0] s_axis_tdata_i,
   input  logic       s_axis_tvalid_i,
   output logic       s_axis_tready_o,
   output logic       busy_o,
   output logic       underrun_o
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      IGNORE
   } state_t;

   // Synchronizers reset to the idle-bus level so reset release creates no edges
   logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
   logic                   scl_hist_reg, sda_hist_reg;
   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, sda_rise, sda_fall;
   logic                   start_det, stop_det;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         scl_sync_reg <= '1;
         sda_sync_reg <= '1;
         scl_hist_reg <= 1'b1;
         sda_hist_reg <= 1'b1;
      end else begin
         scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_i};
         sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_i};
         scl_hist_reg <= scl_s;
         sda_hist_reg <= sda_s;
      end
   end

   assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
   assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_hist_reg;
   assign scl_fall  = ~scl_s & scl_hist_reg;
   assign sda_rise  = sda_s & ~sda_hist_reg;
   assign sda_fall  = ~sda_s & sda_hist_reg;
   assign start_det = sda_fall & scl_s;
   assign stop_det  = sda_rise & scl_s;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [7:0]  shift_reg, shift_next;
   logic        rw_reg, rw_next;
   logic        oe_reg, oe_next;
   logic        ack_plan_reg, ack_plan_next;
   logic        busy_reg, busy_next;
   logic [7:0]  tdata_reg, tdata_next;
   logic        tvalid_reg, tvalid_next;
   logic        fetch;
   logic [7:0]  fetch_byte;
   logic [7:0]  byte_in;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_reg    <= IDLE;
         cnt_reg      <= 4'd0;
         shift_reg    <= 8'h00;
         rw_reg       <= 1'b0;
         oe_reg       <= 1'b0;
         ack_plan_reg <= 1'b0;
         busy_reg     <= 1'b0;
         tdata_reg    <= 8'h00;
         tvalid_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         shift_reg    <= shift_next;
         rw_reg       <= rw_next;
         oe_reg       <= oe_next;
         ack_plan_reg <= ack_plan_next;
         busy_reg     <= busy_next;
         tdata_reg    <= tdata_next;
         tvalid_reg   <= tvalid_next;
      end
   end

   assign fetch_byte = s_axis_tvalid_i ? s_axis_tdata_i : 8'hFF;
   assign byte_in    = {shift_reg[6:0], sda_s};

   // Counter 8 marks the first fall of an ACK bit (drive), 9 the second (release)
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      shift_next    = shift_reg;
      rw_next       = rw_reg;
      oe_next       = oe_reg;
      ack_plan_next = ack_plan_reg;
      busy_next     = busy_reg;
      tdata_next    = tdata_reg;
      tvalid_next   = tvalid_reg;
      fetch         = 1'b0;

      if (tvalid_reg && m_axis_tready_i)
         tvalid_next = 1'b0;

      if (start_det) begin
         state_next = ADDR;
         cnt_next   = 4'd0;
         oe_next    = 1'b0;
      end else if (stop_det) begin
         state_next = IDLE;
         cnt_next   = 4'd0;
         oe_next    = 1'b0;
         busy_next  = 1'b0;
      end else begin
         case (state_reg)
            ADDR: begin
               if (scl_rise) begin
                  shift_next = byte_in;
                  cnt_next   = cnt_reg + 4'd1;
                  if (cnt_reg == 4'd7) begin
                     if (byte_in[7:1] == SLAVE_ADDR) begin
                        busy_next  = 1'b1;
                        rw_next    = byte_in[0];
                        state_next = ADDR_ACK;
                        cnt_next   = 4'd8;
                     end else begin
                        busy_next  = 1'b0;
                        state_next = IGNORE;
                        cnt_next   = 4'd0;
                     end
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (cnt_reg == 4'd8) begin
                     oe_next  = 1'b1;
                     cnt_next = 4'd9;
                  end else begin
                     cnt_next = 4'd0;
                     if (rw_reg) begin
                        fetch      = 1'b1;
                        shift_next = fetch_byte;
                        oe_next    = ~fetch_byte[7];
                        state_next = RD_DATA;
                     end else begin
                        oe_next    = 1'b0;
                        state_next = WR_DATA;
                     end
                  end
               end
            end
            WR_DATA: begin
               if (scl_rise) begin
                  shift_next = byte_in;
                  cnt_next   = cnt_reg + 4'd1;
                  if (cnt_reg == 4'd7) begin
                     // A still-pending byte means the new one is dropped and NACKed
                     if (!tvalid_reg) begin
                        tdata_next    = byte_in;
                        tvalid_next   = 1'b1;
                        ack_plan_next = 1'b1;
                     end else begin
                        ack_plan_next = 1'b0;
                     end
                     state_next = WR_ACK;
                     cnt_next   = 4'd8;
                  end
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  if (cnt_reg == 4'd8) begin
                     oe_next  = ack_plan_reg;
                     cnt_next = 4'd9;
                  end else begin
                     oe_next    = 1'b0;
                     cnt_next   = 4'd0;
                     state_next = ack_plan_reg ? WR_DATA : IGNORE;
                  end
               end
            end
            RD_DATA: begin
               if (scl_fall) begin
                  if (cnt_reg == 4'd7) begin
                     oe_next    = 1'b0;
                     cnt_next   = 4'd8;
                     state_next = RD_ACK;
                  end else begin
                     oe_next    = ~shift_reg[6];
                     shift_next = {shift_reg[6:0], 1'b0};
                     cnt_next   = cnt_reg + 4'd1;
                  end
               end
            end
            RD_ACK: begin
               // A fall is only reached here after an ACK, so the next byte is already loaded
               if (scl_rise) begin
                  if (sda_s) begin
                     state_next = IGNORE;
                     cnt_next   = 4'd0;
                  end else begin
                     fetch      = 1'b1;
                     shift_next = fetch_byte;
                  end
               end else if (scl_fall) begin
                  oe_next    = ~shift_reg[7];
                  cnt_next   = 4'd0;
                  state_next = RD_DATA;
               end
            end
            default: begin
               oe_next = 1'b0;
            end
         endcase
      end
   end

   assign sda_oe_o        = oe_reg;
   assign m_axis_tdata_o  = tdata_reg;
   assign m_axis_tvalid_o = tvalid_reg;
   assign s_axis_tready_o = fetch & s_axis_tvalid_i;
   assign underrun_o      = fetch & ~s_axis_tvalid_i;
   assign busy_o          = busy_reg;

endmodule

// File: tb/tb_i2c_slave_axis.sv
// Bench for i2c_slave_axis: bit-banged I2C master, m_axis scoreboard and s_axis source model.
module tb_i2c_slave_axis;
   localparam int Q = 8;

   logic       clk_i = 1'b0;
   logic       arst_i = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_line;
   logic       sda_oe_o;
   logic [7:0] m_axis_tdata_o;
   logic       m_axis_tvalid_o;
   logic       m_axis_tready_i = 1'b0;
   logic [7:0] s_axis_tdata_i = 8'h00;
   logic       s_axis_tvalid_i = 1'b0;
   logic       s_axis_tready_o;
   logic       busy_o;
   logic       underrun_o;

   int checks = 0;
   int failures = 0;
   int fetch_cnt = 0;
   int underrun_cnt = 0;
   logic fetch_prev = 1'b0;
   logic oe_seen = 1'b0;
   logic [7:0] m_exp_q[$];
   logic [7:0] rd_src_q[$];

   assign sda_line = sda_m & ~sda_oe_o;

   i2c_slave_axis #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .clk_i(clk_i),
      .arst_i(arst_i),
      .scl_i(scl_m),
      .sda_i(sda_line),
      .sda_oe_o(sda_oe_o),
      .m_axis_tdata_o(m_axis_tdata_o),
      .m_axis_tvalid_o(m_axis_tvalid_o),
      .m_axis_tready_i(m_axis_tready_i),
      .s_axis_tdata_i(s_axis_tdata_i),
      .s_axis_tvalid_i(s_axis_tvalid_i),
      .s_axis_tready_o(s_axis_tready_o),
      .busy_o(busy_o),
      .underrun_o(underrun_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // m_axis scoreboard: every accepted byte must match the oldest expected one
   always @(negedge clk_i) begin
      if (m_axis_tvalid_o && m_axis_tready_i) begin
         if (m_exp_q.size() == 0) begin
            check("m_axis_unexpected", {24'h0, m_axis_tdata_o}, 32'hFFFF_FFFF);
         end else begin
            $display("m_axis byte %02h", m_axis_tdata_o);
            check("m_axis_data", {24'h0, m_axis_tdata_o}, {24'h0, m_exp_q.pop_front()});
         end
      end
   end

   // s_axis source: the byte advances one cycle after the fetch strobe
   always @(negedge clk_i) begin
      logic cur;
      cur = s_axis_tready_o;
      if (s_axis_tready_o) fetch_cnt++;
      if (underrun_o) underrun_cnt++;
      if (sda_oe_o) oe_seen = 1'b1;
      if (fetch_prev && rd_src_q.size() != 0) void'(rd_src_q.pop_front());
      s_axis_tvalid_i = (rd_src_q.size() != 0);
      s_axis_tdata_i  = (rd_src_q.size() != 0) ? rd_src_q[0] : 8'h00;
      fetch_prev = cur;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      sda_m = 1'b0; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      sda_m = 1'b1; wait_clk(Q);
   endtask

   task automatic write_bit(input logic b);
      sda_m = b; wait_clk(Q);
      scl_m = 1'b1; wait_clk(2 * Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      b = sda_line; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
      $display("bus write %02h ack_bit=%0b", d, ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(ack);
      $display("bus read %02h master_ack_bit=%0b", d, ack);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       ack;
      logic [7:0] d;
      int         f0, u0;

      wait_clk(4);
      arst_i = 1'b0;
      wait_clk(4);
      check("reset_sda_oe", sda_oe_o, 0);
      check("reset_tvalid", m_axis_tvalid_o, 0);
      check("reset_tdata", m_axis_tdata_o, 0);
      check("reset_busy", busy_o, 0);
      check("reset_s_tready", s_axis_tready_o, 0);
      check("reset_underrun", underrun_o, 0);

      // Plain write with a ready sink
      m_axis_tready_i = 1'b1;
      m_exp_q.push_back(8'h3C);
      m_exp_q.push_back(8'hC3);
      bus_start();
      write_byte(8'hA0, ack); check("wr_addr_ack", ack, 0);
      check("wr_busy_set", busy_o, 1);
      write_byte(8'h3C, ack); check("wr_3c_ack", ack, 0);
      write_byte(8'hC3, ack); check("wr_c3_ack", ack, 0);
      bus_stop();
      wait_clk(4);
      check("wr_busy_clear", busy_o, 0);
      check("wr_bytes_drained", m_exp_q.size(), 0);

      // Wrong address is never acknowledged
      oe_seen = 1'b0;
      bus_start();
      write_byte(8'hA2, ack); check("bad_addr_nack", ack, 1);
      write_byte(8'h55, ack); check("bad_data_nack", ack, 1);
      check("bad_busy", busy_o, 0);
      bus_stop();
      wait_clk(2);
      check("bad_oe_never", oe_seen, 0);

      // Stalled sink: second byte NACKed, first held
      m_axis_tready_i = 1'b0;
      bus_start();
      write_byte(8'hA0, ack); check("stall_addr_ack", ack, 0);
      write_byte(8'h11, ack); check("stall_11_ack", ack, 0);
      write_byte(8'h22, ack); check("stall_22_nack", ack, 1);
      bus_stop();
      wait_clk(4);
      check("stall_tdata", m_axis_tdata_o, 8'h11);
      check("stall_tvalid", m_axis_tvalid_o, 1);
      m_exp_q.push_back(8'h11);
      m_axis_tready_i = 1'b1;
      wait_clk(3);
      check("stall_tvalid_clear", m_axis_tvalid_o, 0);
      check("stall_drained", m_exp_q.size(), 0);

      // Read two bytes, ACK then NACK
      rd_src_q.push_back(8'h5A);
      rd_src_q.push_back(8'h96);
      f0 = fetch_cnt; u0 = underrun_cnt;
      bus_start();
      write_byte(8'hA1, ack); check("rd_addr_ack", ack, 0);
      read_byte(d, 1'b0); check("rd_byte0", d, 8'h5A);
      read_byte(d, 1'b1); check("rd_byte1", d, 8'h96);
      bus_stop();
      wait_clk(4);
      check("rd_fetch_count", fetch_cnt - f0, 2);
      check("rd_underrun_count", underrun_cnt - u0, 0);

      // Read with an empty source
      f0 = fetch_cnt; u0 = underrun_cnt;
      bus_start();
      write_byte(8'hA1, ack); check("ur_addr_ack", ack, 0);
      read_byte(d, 1'b1); check("ur_byte", d, 8'hFF);
      bus_stop();
      wait_clk(4);
      check("ur_underrun_count", underrun_cnt - u0, 1);
      check("ur_fetch_count", fetch_cnt - f0, 0);

      // Partial write, repeated START into a read
      rd_src_q.push_back(8'h3E);
      bus_start();
      write_byte(8'hA0, ack); check("rs_addr_ack", ack, 0);
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
      bus_start();
      write_byte(8'hA1, ack); check("rs_read_ack", ack, 0);
      check("rs_busy", busy_o, 1);
      read_byte(d, 1'b1); check("rs_byte", d, 8'h3E);
      bus_stop();
      wait_clk(4);
      check("rs_no_partial", m_axis_tvalid_o, 0);

      // Reset while driving a 0 read bit with a byte pending on m_axis
      m_axis_tready_i = 1'b0;
      rd_src_q.push_back(8'h00);
      bus_start();
      write_byte(8'hA0, ack); check("ar_addr_ack", ack, 0);
      write_byte(8'h77, ack); check("ar_77_ack", ack, 0);
      bus_start();
      write_byte(8'hA1, ack); check("ar_read_ack", ack, 0);
      check("ar_oe_before", sda_oe_o, 1);
      check("ar_tvalid_before", m_axis_tvalid_o, 1);
      #2 arst_i = 1'b1;
      #1;
      check("ar_oe_after", sda_oe_o, 0);
      check("ar_tvalid_after", m_axis_tvalid_o, 0);
      check("ar_busy_after", busy_o, 0);
      scl_m = 1'b1;
      sda_m = 1'b1;
      wait_clk(3);
      arst_i = 1'b0;
      m_axis_tready_i = 1'b1;
      wait_clk(6);
      check("ar_idle_oe", sda_oe_o, 0);
      check("final_queue_empty", m_exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
